// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the button conditioner: FSM state codes,
// default debounce length and the one-hot test used on accepted vectors.
package condicionador_pkg;

    typedef enum logic [1:0] {
        OCIOSO         = 2'd0,
        PRESSIONADO    = 2'd1,
        ESPERA_SOLTURA = 2'd2
    } estado_t;

    localparam int DEBOUNCE_CYCLES_PADRAO = 4;

    // Widest button vector the one-hot helper handles; callers zero-extend.
    localparam int N_BOTOES_MAX = 32;

    // True only for a nonzero vector with a single bit set.
    function automatic logic eh_one_hot(input logic [N_BOTOES_MAX-1:0] vetor);
        logic [N_BOTOES_MAX-1:0] um;
        um = {{(N_BOTOES_MAX-1){1'b0}}, 1'b1};
        return (vetor != '0) && ((vetor & (vetor - um)) == '0);
    endfunction

endpackage

// File: rtl/condicionador_botoes_debounce.sv
// Two-stage synchroniser followed by a candidate/counter debouncer.
// A new vector must be seen unchanged for DEBOUNCE_CYCLES consecutive
// cycles after it becomes the candidate before it is copied to estavel.
module debounce_vetor
    import condicionador_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_i,
    output logic [N_BOTOES-1:0] estavel_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BOTOES-1:0] s1_q;
    logic [N_BOTOES-1:0] s2_q;
    logic [N_BOTOES-1:0] candidato_q, candidato_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_BOTOES-1:0] estavel_q, estavel_d;

    // Restart the count on any change, otherwise count up to the limit
    // (saturating) and then keep publishing the candidate as stable.
    always_comb begin
        candidato_d = candidato_q;
        cnt_d       = cnt_q;
        estavel_d   = estavel_q;
        if (s2_q != candidato_q) begin
            candidato_d = s2_q;
            cnt_d       = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            estavel_d = candidato_q;
        end
    end

    // Synchroniser and debounce registers, cleared by the active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            candidato_q <= '0;
            cnt_q       <= '0;
            estavel_q   <= '0;
        end else begin
            s1_q        <= botoes_i;
            s2_q        <= s1_q;
            candidato_q <= candidato_d;
            cnt_q       <= cnt_d;
            estavel_q   <= estavel_d;
        end
    end

    assign estavel_o = estavel_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Button input stage of the memory game: debounces the raw buttons and
// turns each full press/release cycle into one valid or invalid jogada.
module condicionador_botoes
    import condicionador_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    input  logic                limpa,
    output logic                jogada_valida,
    output logic                jogada_invalida,
    output logic [N_BOTOES-1:0] jogada,
    output logic                pressionado,
    output logic [1:0]          db_estado
);

    logic [N_BOTOES-1:0] estavel;

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                valida_q, valida_d;
    logic                invalida_q, invalida_d;
    logic                pressionado_q, pressionado_d;

    debounce_vetor #(
        .N_BOTOES        (N_BOTOES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .botoes_i  (botoes),
        .estavel_o (estavel)
    );

    // Next-state and output decode; only OCIOSO can accept a press, and an
    // acceptance overrides a simultaneous limpa on the jogada register.
    always_comb begin
        estado_d      = estado_q;
        jogada_d      = limpa ? '0 : jogada_q;
        valida_d      = 1'b0;
        invalida_d    = 1'b0;
        pressionado_d = (estavel != '0);
        case (estado_q)
            ESPERA_SOLTURA: begin
                if (estavel == '0) estado_d = OCIOSO;
            end
            OCIOSO: begin
                if (estavel != '0) begin
                    if (habilita) begin
                        if (eh_one_hot(N_BOTOES_MAX'(estavel))) begin
                            valida_d = 1'b1;
                            jogada_d = estavel;
                        end else begin
                            invalida_d = 1'b1;
                        end
                        estado_d = PRESSIONADO;
                    end else begin
                        estado_d = ESPERA_SOLTURA;
                    end
                end
            end
            PRESSIONADO: begin
                if (estavel == '0) estado_d = OCIOSO;
            end
            default: estado_d = ESPERA_SOLTURA;
        endcase
    end

    // State and output registers; reset starts in ESPERA_SOLTURA so a
    // press must be released before anything is accepted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q      <= ESPERA_SOLTURA;
            jogada_q      <= '0;
            valida_q      <= 1'b0;
            invalida_q    <= 1'b0;
            pressionado_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            jogada_q      <= jogada_d;
            valida_q      <= valida_d;
            invalida_q    <= invalida_d;
            pressionado_q <= pressionado_d;
        end
    end

    assign jogada_valida   = valida_q;
    assign jogada_invalida = invalida_q;
    assign jogada          = jogada_q;
    assign pressionado     = pressionado_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with default parameters
// (4 buttons, 4 debounce cycles, press-to-pulse latency of 7 edges).
module tb_condicionador_botoes;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       limpa;
    logic       jogada_valida;
    logic       jogada_invalida;
    logic [3:0] jogada;
    logic       pressionado;
    logic [1:0] db_estado;

    int total = 0;
    int bad   = 0;

    condicionador_botoes dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .limpa           (limpa),
        .jogada_valida   (jogada_valida),
        .jogada_invalida (jogada_invalida),
        .jogada          (jogada),
        .pressionado     (pressionado),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n cycles (sampling at negedge) and count pulses seen.
    task automatic ciclos(input int n, output int nv, output int ni);
        nv = 0;
        ni = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (jogada_valida === 1'b1) nv++;
            if (jogada_invalida === 1'b1) ni++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; botoes = 4'b0000; habilita = 1'b0; limpa = 1'b0;
        @(negedge clock);
        total++;
        if ({jogada_valida, jogada_invalida, jogada, pressionado} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_saidas: got=%b want=0000000",
                     {jogada_valida, jogada_invalida, jogada, pressionado});
        end
        total++;
        if (db_estado !== 2'd2) begin
            bad++; $display("[TB] FAIL reset_estado: got=%0d want=2", db_estado);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (db_estado !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_ocioso: got=%0d want=0", db_estado);
        end
    endtask

    task automatic test_valida;
        int nv, ni, cv;
        habilita = 1'b1;
        botoes = 4'b0010;
        cv = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (jogada_valida === 1'b1) cv++;
            total++;
            if (jogada_valida !== (i == 8)) begin
                bad++;
                $display("[TB] FAIL valida_tempo c%0d: got=%b want=%b", i, jogada_valida, (i == 8));
            end
            if (i == 8) begin
                total++;
                if (jogada !== 4'b0010) begin
                    bad++; $display("[TB] FAIL valida_codigo: got=%b want=0010", jogada);
                end
            end
        end
        total++;
        if (pressionado !== 1'b1) begin
            bad++; $display("[TB] FAIL valida_pressionado: got=%b want=1", pressionado);
        end
        total++;
        if (cv !== 1) begin
            bad++; $display("[TB] FAIL valida_contagem: got=%0d want=1", cv);
        end
        botoes = 4'b0000;
        ciclos(10, nv, ni);
        total++;
        if ({db_estado, jogada, pressionado} !== {2'd0, 4'b0010, 1'b0}) begin
            bad++;
            $display("[TB] FAIL valida_soltura: got=%0d/%b/%b want=0/0010/0", db_estado, jogada, pressionado);
        end
    endtask

    task automatic test_glitch;
        int nv, ni, pmax;
        pmax = 0;
        botoes = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (pressionado === 1'b1) pmax = 1;
        end
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (pressionado === 1'b1) pmax = 1;
            if (jogada_valida === 1'b1 || jogada_invalida === 1'b1) pmax = pmax + 2;
        end
        total++;
        if (pmax !== 0) begin
            bad++; $display("[TB] FAIL glitch_ignorado: got=%0d want=0", pmax);
        end
        total++;
        if (jogada !== 4'b0010) begin
            bad++; $display("[TB] FAIL glitch_jogada: got=%b want=0010", jogada);
        end
    endtask

    task automatic test_invalida;
        int nv, ni, cv, ci;
        cv = 0; ci = 0;
        botoes = 4'b0101;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (jogada_valida === 1'b1) cv++;
            if (jogada_invalida === 1'b1) ci++;
            if (i == 8) begin
                total++;
                if (jogada_invalida !== 1'b1) begin
                    bad++; $display("[TB] FAIL invalida_tempo: got=%b want=1", jogada_invalida);
                end
            end
        end
        total++;
        if ({cv, ci} !== {32'd0, 32'd1}) begin
            bad++; $display("[TB] FAIL invalida_pulsos: got=v%0d/i%0d want=v0/i1", cv, ci);
        end
        total++;
        if (jogada !== 4'b0010) begin
            bad++; $display("[TB] FAIL invalida_jogada: got=%b want=0010", jogada);
        end
        botoes = 4'b0000;
        ciclos(10, nv, ni);
    endtask

    // Exactly DEBOUNCE_CYCLES held cycles is filtered; one more is accepted.
    task automatic test_limiar;
        int nv, ni, n2v, n2i;
        botoes = 4'b0001;
        ciclos(4, nv, ni);
        botoes = 4'b0000;
        ciclos(12, n2v, n2i);
        total++;
        if (nv + n2v + ni + n2i !== 0) begin
            bad++; $display("[TB] FAIL limiar_4ciclos: got=%0d want=0", nv + n2v + ni + n2i);
        end
        botoes = 4'b0001;
        ciclos(5, nv, ni);
        botoes = 4'b0000;
        ciclos(12, n2v, n2i);
        total++;
        if ({nv + n2v, jogada} !== {32'd1, 4'b0001}) begin
            bad++; $display("[TB] FAIL limiar_5ciclos: got=%0d/%b want=1/0001", nv + n2v, jogada);
        end
    endtask

    task automatic test_rolagem;
        int v1, i1, v2, i2, v3, i3;
        botoes = 4'b1000;
        ciclos(10, v1, i1);
        botoes = 4'b1100;
        ciclos(10, v2, i2);
        botoes = 4'b0100;
        ciclos(10, v3, i3);
        total++;
        if ({v1 + v2 + v3, i1 + i2 + i3} !== {32'd1, 32'd0}) begin
            bad++;
            $display("[TB] FAIL rolagem_pulsos: got=v%0d/i%0d want=v1/i0", v1 + v2 + v3, i1 + i2 + i3);
        end
        total++;
        if (jogada !== 4'b1000) begin
            bad++; $display("[TB] FAIL rolagem_jogada: got=%b want=1000", jogada);
        end
        botoes = 4'b0000;
        ciclos(10, v1, i1);
    endtask

    task automatic test_habilita;
        int nv, ni, tv;
        tv = 0;
        habilita = 1'b0;
        botoes = 4'b0001;
        ciclos(10, nv, ni);
        tv += nv + ni;
        total++;
        if (db_estado !== 2'd2) begin
            bad++; $display("[TB] FAIL habilita_espera: got=%0d want=2", db_estado);
        end
        habilita = 1'b1;
        ciclos(10, nv, ni);
        tv += nv + ni;
        total++;
        if (db_estado !== 2'd2) begin
            bad++; $display("[TB] FAIL habilita_tardio: got=%0d want=2", db_estado);
        end
        botoes = 4'b0000;
        ciclos(10, nv, ni);
        tv += nv + ni;
        total++;
        if ({tv, db_estado, jogada} !== {32'd0, 2'd0, 4'b1000}) begin
            bad++; $display("[TB] FAIL habilita_bloqueio: got=%0d/%0d/%b want=0/0/1000", tv, db_estado, jogada);
        end
        botoes = 4'b0001;
        ciclos(10, nv, ni);
        total++;
        if ({nv, jogada} !== {32'd1, 4'b0001}) begin
            bad++; $display("[TB] FAIL habilita_nova: got=%0d/%b want=1/0001", nv, jogada);
        end
        botoes = 4'b0000;
        ciclos(10, nv, ni);
    endtask

    // limpa held during a press: the acceptance cycle loads the code,
    // the following cycles with limpa still high clear it again.
    task automatic test_limpa;
        limpa = 1'b1;
        botoes = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 1) begin
                total++;
                if (jogada !== 4'b0000) begin
                    bad++; $display("[TB] FAIL limpa_idle: got=%b want=0000", jogada);
                end
            end
            if (i == 8) begin
                total++;
                if ({jogada_valida, jogada} !== 5'b1_0100) begin
                    bad++; $display("[TB] FAIL limpa_prioridade: got=%b want=10100", {jogada_valida, jogada});
                end
            end
        end
        total++;
        if (jogada !== 4'b0000) begin
            bad++; $display("[TB] FAIL limpa_apos: got=%b want=0000", jogada);
        end
        limpa = 1'b0;
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) @(negedge clock);
    endtask

    // Reset lands on the edge that would have produced the pulse.
    task automatic test_reset_meio;
        int nv, ni;
        botoes = 4'b1000;
        for (int i = 0; i < 7; i++) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({jogada_valida, jogada_invalida, jogada, pressionado, db_estado} !== 9'b0_0_0000_0_10) begin
            bad++;
            $display("[TB] FAIL reset_meio: got=%b want=000000010",
                     {jogada_valida, jogada_invalida, jogada, pressionado, db_estado});
        end
        reset = 1'b1;
        botoes = 4'b0000;
        ciclos(10, nv, ni);
        total++;
        if ({nv + ni, db_estado} !== {32'd0, 2'd0}) begin
            bad++; $display("[TB] FAIL reset_meio_ocioso: got=%0d/%0d want=0/0", nv + ni, db_estado);
        end
        botoes = 4'b0001;
        ciclos(10, nv, ni);
        total++;
        if ({nv, jogada} !== {32'd1, 4'b0001}) begin
            bad++; $display("[TB] FAIL reset_meio_nova: got=%0d/%b want=1/0001", nv, jogada);
        end
        botoes = 4'b0000;
        ciclos(10, nv, ni);
    endtask

    task automatic test_sequencia;
        int nv, ni, soma, erros;
        logic [3:0] codigo;
        soma = 0; erros = 0;
        for (int p = 0; p < 16; p++) begin
            codigo = 4'b0001 << (p % 4);
            botoes = codigo;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clock);
                if (jogada_valida === 1'b1) begin
                    soma++;
                    if (jogada !== codigo) erros++;
                end
            end
            botoes = 4'b0000;
            ciclos(10, nv, ni);
            soma += nv;
        end
        total++;
        if ({soma, erros} !== {32'd16, 32'd0}) begin
            bad++; $display("[TB] FAIL sequencia: got=%0d pulsos/%0d erros want=16/0", soma, erros);
        end
    endtask

    initial begin
        test_reset();
        test_valida();
        test_glitch();
        test_invalida();
        test_limiar();
        test_rolagem();
        test_habilita();
        test_limpa();
        test_reset_meio();
        test_sequencia();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Upstream input stage of the memory-game datapath. Sits between the physical `botoes[3:0]` pins and the game circuit's jogada-capture logic.
- Synchronises and debounces the raw button vector.
- Emits a single-cycle `jogada_valida` pulse per accepted press, with the one-hot code held in `jogada`.
- Rejects multi-button presses with `jogada_invalida`.
- Requires full release between presses, so one physical press yields exactly one jogada.

Parameters:
- N_BOTOES, 4, width of the button vector.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a vector change is accepted; minimum 1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset (sampled on rising edge of clock; 0 = reset).
- botoes  in  N_BOTOES  raw asynchronous button inputs, 1 = pressed.
- habilita  in  1  1 = presses may be accepted; 0 = presses ignored.
- limpa  in  1  synchronous clear of `jogada` register.
- jogada_valida  out  1  one-cycle pulse on accepted one-hot press.
- jogada_invalida  out  1  one-cycle pulse on accepted multi-hot press.
- jogada  out  N_BOTOES  last accepted one-hot code; held until next valid press or limpa.
- pressionado  out  1  level; debounced vector nonzero.
- db_estado  out  2  FSM state code for debug.

Behaviour:
- Reset (reset=0 at an edge) clears every register:
  - sync stages, candidate vector, counter and estavel = 0.
  - jogada = 0, jogada_valida = 0, jogada_invalida = 0, pressionado = 0.
  - FSM = ESPERA_SOLTURA, so db_estado = 2.
  - Reset mid-press aborts any pending pulse; no pulse is emitted in the reset cycle.
- Synchroniser: two flip-flop stages (s1, s2) per bit.
- Debounce:
  - If s2 != candidate: candidate <= s2, cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt++.
  - Else: estavel <= candidate.
  - cnt is width clog2(DEBOUNCE_CYCLES)+1 and saturates; it never wraps.
- Latency: botoes changes before edge k and is held.
  - estavel updates at edge k+DEBOUNCE_CYCLES+2.
  - jogada_valida/invalida is high for exactly one cycle following edge k+DEBOUNCE_CYCLES+3. With the default of 4, that is 7 cycles.
  - Any input pattern held fewer than DEBOUNCE_CYCLES+1 cycles never reaches estavel.
- pressionado is registered as (estavel != 0), one cycle after estavel.
- FSM, states encoded OCIOSO=0, PRESSIONADO=1, ESPERA_SOLTURA=2:
  - ESPERA_SOLTURA: estavel==0 → OCIOSO. This blocks a button already held when reset releases.
  - OCIOSO, estavel!=0 and habilita=1:
    - If estavel is one-hot: pulse jogada_valida, jogada <= estavel, → PRESSIONADO.
    - Otherwise: pulse jogada_invalida, jogada unchanged, → PRESSIONADO.
  - OCIOSO, estavel!=0 and habilita=0: no pulse, → ESPERA_SOLTURA.
  - PRESSIONADO: estavel==0 → OCIOSO. Changes between nonzero values while in this state (rolling to another button, adding a second button) produce no pulse.
- At most one of jogada_valida/jogada_invalida is high in any cycle. Neither pulses in two consecutive cycles.
- limpa=1 sets jogada <= 0. If a valid acceptance occurs in the same cycle, the new code is loaded (acceptance wins).
- habilita is sampled only in OCIOSO. Dropping habilita while in PRESSIONADO has no effect on the current press.

Decomposition:
- Package condicionador_pkg holds:
  - FSM state encoding constants (OCIOSO, PRESSIONADO, ESPERA_SOLTURA).
  - Default DEBOUNCE_CYCLES.
  - A one-hot check function, true iff the vector is nonzero and vector & (vector-1) == 0.
- Sub-module debounce_vetor contains the two-stage synchroniser plus the candidate/counter logic. It is parameterised by N_BOTOES and DEBOUNCE_CYCLES and outputs estavel.
- condicionador_botoes instantiates debounce_vetor and contains the FSM and output registers.

Test Plan:
- Reset held for 1 cycle with botoes=0000 → all outputs 0, db_estado=2. After 1 cycle with estavel=0 → db_estado=0.
- habilita=1; botoes=0010 held 10 cycles from edge k → jogada_valida=1 only in the cycle after edge k+7, jogada=0010, pressionado=1. After release, db_estado returns to 0 and jogada stays 0010.
- Glitch: botoes=0100 for 3 cycles then 0000 → no pulse, jogada unchanged, pressionado stays 0.
- botoes=0101 held 10 cycles → jogada_invalida single pulse, jogada_valida stays 0, jogada unchanged.
- botoes=1000 held across reset release → no pulse. After release, a new press of 0001 produces jogada_valida with jogada=0001.
- habilita=0 during a press of 0001 → no pulse, db_estado=2. Set habilita=1 while still held → still no pulse until release followed by a new press.
- A sequence of 16 presses (0001, 0010, 0100, 1000, …), each held 10 cycles with 10 cycles released between them → exactly 16 jogada_valida pulses, and jogada matches each code in order.
